basic_gates_checker: RTL and testbench

BASIC_GATES_CHECKER -- requirements
Module: basic_gates_checker

---
 rtl/basic_gates_checker.sv | 109 ++++++++++
 tb/tb_basic_gates_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_gates_checker.sv
// Exhaustive self-test sequencer for a 2-input basic gate block: applies all four
// {a,b} vectors, compares the six observed gate outputs and reports the first failure.
module basic_gates_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [5:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec,
    output logic [5:0] fail_mask
);

    localparam logic       ST_IDLE     = 1'b0;
    localparam logic       ST_RUN      = 1'b1;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic       r_state;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [1:0] r_fail_vec;
    logic [5:0] r_fail_mask;

    logic       w_a;
    logic       w_b;
    logic [5:0] w_expected;
    logic [5:0] w_mismatch;
    logic       w_bad;
    logic       w_sample;
    logic [2:0] w_err_next;

    assign w_a        = r_vec[1];
    assign w_b        = r_vec[0];
    assign w_expected = {w_a & w_b, w_a | w_b, ~(w_a & w_b), ~(w_a | w_b), w_a ^ w_b, ~(w_a ^ w_b)};
    assign w_mismatch = gate_in ^ w_expected;
    assign w_bad      = |w_mismatch;
    // Sampling edge: the current vector has been held for SETTLE cycles.
    assign w_sample   = (r_state == ST_RUN) && (r_cnt == SETTLE_LAST);
    assign w_err_next = r_err + {2'b00, w_bad};

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_vec       <= 2'b00;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= 3'd0;
            r_fail_vec  <= 2'b00;
            r_fail_mask <= 6'b000000;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_state     <= ST_RUN;
                    r_busy      <= 1'b1;
                    r_vec       <= 2'b00;
                    r_cnt       <= 4'd0;
                    r_pass      <= 1'b0;
                    r_err       <= 3'd0;
                    r_fail_vec  <= 2'b00;
                    r_fail_mask <= 6'b000000;
                end
            end else if (w_sample) begin
                r_cnt <= 4'd0;
                r_err <= w_err_next;
                // Only the first failing vector of a run is recorded.
                if (w_bad && (r_err == 3'd0)) begin
                    r_fail_vec  <= r_vec;
                    r_fail_mask <= w_mismatch;
                end
                if (r_vec == 2'd3) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_next == 3'd0);
                    r_vec   <= 2'b00;
                end else begin
                    r_vec <= r_vec + 2'd1;
                end
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign a         = w_a;
    assign b         = w_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail_vec;
    assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_basic_gates_checker.sv
// Bench for basic_gates_checker: two instances (SETTLE=1 and SETTLE=3), each driven by
// a configurable gate model (per-vector fault masks or a 2-cycle registered pipeline).
module tb_basic_gates_checker;

    typedef struct packed {
        logic            sel;      // 0: SETTLE=1 instance, 1: SETTLE=3 instance
        logic            use_reg;  // gate model is the 2-cycle registered pipeline
        logic [3:0][5:0] fm;       // per-vector fault mask XORed onto correct outputs
        logic            pass;
        logic [2:0]      err;
        logic [1:0]      fv;
        logic [5:0]      mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;
    logic a1, b1, busy1, done1, pass1, a3, b3, busy3, done3, pass3;
    logic [2:0] err1, err3;
    logic [1:0] fv1, fv3;
    logic [5:0] mask1, mask3, gate1, gate3;
    logic [5:0] fm1 [4];
    logic [5:0] fm3 [4];
    logic use1 = 1'b0, use3 = 1'b0;
    logic [5:0] p1_s1, p1_s2, p3_s1, p3_s2;

    int n_checks = 0;
    int n_err = 0;

    logic       cur = 1'b0;
    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [2:0] m_err;
    logic [1:0] m_fv;
    logic [5:0] m_mask;

    always #5 clk = ~clk;

    basic_gates_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .gate_in(gate1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fv1), .fail_mask(mask1)
    );

    basic_gates_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .gate_in(gate3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_vec(fv3), .fail_mask(mask3)
    );

    // Truth of each gate computed arithmetically from operand values.
    function automatic logic [5:0] truth(input logic xa, input logic xb);
        int va = int'(xa);
        int vb = int'(xb);
        logic [5:0] r;
        r[5] = (va * vb) == 1;
        r[4] = (va + vb) != 0;
        r[3] = !r[5];
        r[2] = !r[4];
        r[1] = (va + vb) == 1;
        r[0] = !r[1];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        p1_s1 <= truth(a1, b1);
        p1_s2 <= p1_s1;
        p3_s1 <= truth(a3, b3);
        p3_s2 <= p3_s1;
    end

    always_comb begin
        gate1 = use1 ? p1_s2 : (truth(a1, b1) ^ fm1[{a1, b1}]);
        gate3 = use3 ? p3_s2 : (truth(a3, b3) ^ fm3[{a3, b3}]);
    end

    always_comb begin
        m_a = a1; m_b = b1; m_busy = busy1; m_done = done1; m_pass = pass1;
        m_err = err1; m_fv = fv1; m_mask = mask1;
        if (cur) begin
            m_a = a3; m_b = b3; m_busy = busy3; m_done = done3; m_pass = pass3;
            m_err = err3; m_fv = fv3; m_mask = mask3;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic sel, input logic val);
        if (sel) start3 = val;
        else     start1 = val;
    endtask

    task automatic set_model(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            if (v.sel) fm3[k] = v.fm[k];
            else       fm1[k] = v.fm[k];
        end
        if (v.sel) use3 = v.use_reg;
        else       use1 = v.use_reg;
    endtask

    // Called #1 after the accepting edge; returns cycles until done is seen (bounded).
    task automatic wait_done(input string tag, input int settle, output int lat);
        lat = 0;
        while (m_done !== 1'b1 && lat <= 4 * settle + 4) begin
            if (lat < 4 * settle) begin
                check({tag, "_busy"}, 32'(m_busy), 32'd1);
                check({tag, "_vec"}, 32'({m_a, m_b}), 32'(lat / settle));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(4 * settle));
    endtask

    task automatic check_results(input string tag, input vec_t v);
        check({tag, "_pass"}, 32'(m_pass), 32'(v.pass));
        check({tag, "_err"}, 32'(m_err), 32'(v.err));
        check({tag, "_fvec"}, 32'(m_fv), 32'(v.fv));
        check({tag, "_fmask"}, 32'(m_mask), 32'(v.mask));
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        int settle = v.sel ? 3 : 1;
        int lat;
        cur = v.sel;
        set_model(v);
        repeat (3) @(posedge clk);
        #1 set_start(v.sel, 1'b1);
        @(posedge clk); #1;
        set_start(v.sel, 1'b0);
        wait_done(tag, settle, lat);
        check_results(tag, v);
        check({tag, "_idle_ab"}, 32'({m_a, m_b, m_busy}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_once"}, 32'(m_done), 32'd0);
        check_results({tag, "_held"}, v);
    endtask

    // Reference: result of a run is determined by which vectors carry a fault.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r = v;
        int first = -1;
        r.err = 3'd0; r.fv = 2'd0; r.mask = 6'd0;
        for (int k = 0; k < 4; k++) begin
            if (v.fm[k] != 6'd0) begin
                r.err = r.err + 3'd1;
                if (first < 0) begin
                    first  = k;
                    r.fv   = 2'(k);
                    r.mask = v.fm[k];
                end
            end
        end
        r.pass = (r.err == 3'd0);
        return r;
    endfunction

    vec_t tbl [6];

    initial begin
        int lat;
        int pulses;
        vec_t v;

        for (int k = 0; k < 4; k++) begin fm1[k] = 6'd0; fm3[k] = 6'd0; end

        tbl[0] = '{sel: 1'b0, use_reg: 1'b0, fm: '0, pass: 1'b1, err: 3'd0, fv: 2'd0, mask: 6'd0};
        tbl[1] = '{sel: 1'b0, use_reg: 1'b0, fm: {6'b100000, 6'd0, 6'd0, 6'd0},
                   pass: 1'b0, err: 3'd1, fv: 2'b11, mask: 6'b100000};
        tbl[2] = '{sel: 1'b0, use_reg: 1'b0, fm: {4{6'b000011}},
                   pass: 1'b0, err: 3'd4, fv: 2'b00, mask: 6'b000011};
        tbl[3] = '{sel: 1'b0, use_reg: 1'b1, fm: '0, pass: 1'b0, err: 3'd3, fv: 2'b01, mask: 6'b010111};
        tbl[4] = '{sel: 1'b1, use_reg: 1'b1, fm: '0, pass: 1'b1, err: 3'd0, fv: 2'd0, mask: 6'd0};
        tbl[5] = '{sel: 1'b1, use_reg: 1'b0, fm: {6'd0, 6'b110000, 6'd0, 6'b000001},
                   pass: 1'b0, err: 3'd2, fv: 2'b00, mask: 6'b000001};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_dut1", 32'({a1, b1, busy1, done1, pass1, err1, fv1, mask1}), 32'd0);
        check("rst_dut3", 32'({a3, b3, busy3, done3, pass3, err3, fv3, mask3}), 32'd0);

        for (int i = 0; i < 6; i++) run_and_check($sformatf("tbl%0d", i), tbl[i]);

        // Randomized fault patterns against the reference model
        for (int i = 0; i < 16; i++) begin
            v = '0;
            v.sel = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++)
                v.fm[k] = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(1, 63));
            run_and_check($sformatf("rnd%0d", i), ref_model(v));
        end

        // start re-pulsed while busy must not disturb the run
        cur = 1'b0;
        set_model(tbl[0]);
        repeat (3) @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat <= 8) begin
            start1 = (lat == 1 || lat == 2);
            @(posedge clk); #1;
            lat++;
        end
        start1 = 1'b0;
        check("repulse_latency", 32'(lat), 32'd4);
        check("repulse_pass", 32'(pass1), 32'd1);
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        check("repulse_single_done", 32'(pulses), 32'd0);

        // Reset mid-run aborts, clearing previously recorded failure results
        run_and_check("pre_abort", tbl[1]);
        #1 start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", 32'({a1, b1, busy1, done1, pass1, err1, fv1, mask1}), 32'd0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done1 || busy1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // start coincident with rst is discarded
        rst = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start1 = 1'b0;
        check("rst_start_busy", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        check("rst_start_busy2", 32'(busy1), 32'd0);

        // start held during the done cycle launches a back-to-back run
        cur = 1'b1;
        set_model(tbl[5]);
        repeat (3) @(posedge clk);
        #1 start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        wait_done("b2b_first", 3, lat);
        check_results("b2b_first", tbl[5]);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        check("b2b_restart", 32'({done3, busy3, err3}), 32'({1'b0, 1'b1, 3'd0}));
        wait_done("b2b_second", 3, lat);
        check_results("b2b_second", tbl[5]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
